// File: rtl/syzygy_adc_dco_pkg.sv
// Shared types and default timing constants for the ADC DCO MMCM controller.
package syzygy_adc_dco_pkg;

    typedef enum logic [2:0] {
        ST_MMCM_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RELEASE,
        ST_RUN,
        ST_PS_WAIT,
        ST_FAULT
    } dco_state_t;

    localparam int DEF_NUM_CHANNELS    = 8;
    localparam int DEF_PHASE_W         = 10;
    localparam int DEF_MMCM_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT    = 65535;
    localparam int DEF_SETTLE_CYCLES   = 1024;
    localparam int DEF_PS_TIMEOUT      = 255;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'hFF;

endpackage

// File: rtl/syzygy_adc_dco_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous MMCM LOCKED into the clk domain.
module syzygy_adc_dco_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
        end
    end

    assign sync_out = sync;

endmodule

// File: rtl/syzygy_adc_dco_ctrl.sv
// DCO MMCM reset/lock sequencing, staggered ISERDES release and dynamic phase stepping.
// Define SYZYGY_ADC_DCO_AUTO_RELOCK_EN to rerun the reset sequence on lock loss instead of faulting.
module syzygy_adc_dco_ctrl
    import syzygy_adc_dco_pkg::*;
#(
    parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int PHASE_W         = DEF_PHASE_W,
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int PS_TIMEOUT      = DEF_PS_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mmcm_locked,
    output logic                      mmcm_rst,
    output logic                      ps_en,
    output logic                      ps_incdec,
    input  logic                      ps_done,
    input  logic signed [PHASE_W-1:0] phase_target,
    input  logic                      phase_load,
    output logic signed [PHASE_W-1:0] phase_current,
    output logic                      ps_busy,
    output logic [NUM_CHANNELS-1:0]   serdes_rst,
    output logic                      ready,
    output logic                      fault,
    output logic [7:0]                lock_loss_cnt
);

    dco_state_t state, state_next;
    logic [31:0] cnt;
    logic signed [PHASE_W-1:0] target_q;
    logic locked_s;
    logic step_issue, step_done, lock_lost, ps_timeout;

    syzygy_adc_dco_lock_sync u_lock_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (mmcm_locked),
        .sync_out (locked_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_MMCM_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mmcm_rst   = 1'b0;
        serdes_rst = '1;
        ready      = 1'b0;
        step_issue = 1'b0;
        step_done  = 1'b0;
        lock_lost  = 1'b0;
        ps_timeout = 1'b0;
        case (state)
            ST_MMCM_RST: begin
                mmcm_rst = 1'b1;
                if (cnt == 32'(MMCM_RST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) state_next = ST_SETTLE;
                else if (cnt == 32'(LOCK_TIMEOUT - 1)) state_next = ST_MMCM_RST;
            end
            ST_SETTLE: begin
                // The WAIT_LOCK cycle that saw lock counts as the first settle cycle.
                if (!locked_s) state_next = ST_WAIT_LOCK;
                else if (cnt >= 32'(SETTLE_CYCLES - 1)) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else begin
                    for (int i = 0; i < NUM_CHANNELS; i++) serdes_rst[i] = (cnt < 32'(i));
                    if (cnt == 32'(NUM_CHANNELS - 1)) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else begin
                    serdes_rst = '0;
                    ready      = 1'b1;
                    if (phase_current != target_q) begin
                        step_issue = 1'b1;
                        state_next = ST_PS_WAIT;
                    end
                end
            end
            ST_PS_WAIT: begin
                if (!locked_s) begin
                    lock_lost = 1'b1;
                end else begin
                    serdes_rst = '0;
                    ready      = 1'b1;
                    if (ps_done) begin
                        step_done  = 1'b1;
                        state_next = ST_RUN;
                    end else if (cnt == 32'(PS_TIMEOUT - 1)) begin
                        ps_timeout = 1'b1;
                        state_next = ST_FAULT;
                    end
                end
            end
            default: ;
        endcase
        if (lock_lost) begin
`ifdef SYZYGY_ADC_DCO_AUTO_RELOCK_EN
            state_next = ST_MMCM_RST;
`else
            state_next = ST_FAULT;
`endif
        end
    end

    // Per-state cycle counter; SETTLE starts at 1 to credit the cycle lock was first seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= (state_next == ST_SETTLE) ? 32'd1 : 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_en         <= 1'b0;
            ps_incdec     <= 1'b0;
            phase_current <= '0;
            target_q      <= '0;
            fault         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            ps_en <= step_issue;
            if (step_issue) ps_incdec <= (target_q > phase_current);
            // An MMCM reset discards its dynamic phase, so the tracked offset follows.
            if (state == ST_MMCM_RST) begin
                phase_current <= '0;
            end else if (step_done) begin
                phase_current <= ps_incdec ? phase_current + PHASE_W'(1)
                                           : phase_current - PHASE_W'(1);
            end
            if (phase_load) target_q <= phase_target;
            if (lock_lost && lock_loss_cnt != LOCK_LOSS_MAX) lock_loss_cnt <= lock_loss_cnt + 8'd1;
`ifdef SYZYGY_ADC_DCO_AUTO_RELOCK_EN
            if (ps_timeout) fault <= 1'b1;
`else
            if (ps_timeout || lock_lost) fault <= 1'b1;
`endif
        end
    end

    assign ps_busy = (phase_current != target_q) || (state == ST_PS_WAIT);

endmodule

// File: tb/tb_syzygy_adc_dco_ctrl.sv
// Directed-plus-random bench for syzygy_adc_dco_ctrl with a behavioural MMCM phase-shift responder.
module tb_syzygy_adc_dco_ctrl;

    localparam int NCH   = 4;
    localparam int PW    = 10;
    localparam int RSTC  = 4;
    localparam int LTO   = 100;
    localparam int SETC  = 8;
    localparam int PSTO  = 20;

    logic clk = 1'b0;
    logic reset;
    logic mmcm_locked;
    logic mmcm_rst;
    logic ps_en;
    logic ps_incdec;
    logic ps_done;
    logic signed [PW-1:0] phase_target;
    logic phase_load;
    logic signed [PW-1:0] phase_current;
    logic ps_busy;
    logic [NCH-1:0] serdes_rst;
    logic ready;
    logic fault;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad = 0;
    int inc_count = 0;
    int dec_count = 0;
    bit resp_on = 1'b1;
    int resp_delay = 2;

    syzygy_adc_dco_ctrl #(
        .NUM_CHANNELS    (NCH),
        .PHASE_W         (PW),
        .MMCM_RST_CYCLES (RSTC),
        .LOCK_TIMEOUT    (LTO),
        .SETTLE_CYCLES   (SETC),
        .PS_TIMEOUT      (PSTO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mmcm_locked   (mmcm_locked),
        .mmcm_rst      (mmcm_rst),
        .ps_en         (ps_en),
        .ps_incdec     (ps_incdec),
        .ps_done       (ps_done),
        .phase_target  (phase_target),
        .phase_load    (phase_load),
        .phase_current (phase_current),
        .ps_busy       (ps_busy),
        .serdes_rst    (serdes_rst),
        .ready         (ready),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // MMCM phase-shift port model: logs every PSEN and answers with PSDONE after resp_delay cycles.
    initial begin
        ps_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ps_en === 1'b1) begin
                if (ps_incdec === 1'b1) inc_count++;
                else dec_count++;
                if (resp_on) begin
                    repeat (resp_delay) begin
                        @(posedge clk);
                        #2;
                    end
                    ps_done = 1'b1;
                    @(posedge clk);
                    #2;
                    ps_done = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic applyStimulus(input int target);
        phase_target = PW'(target);
        phase_load = 1'b1;
        tick();
        phase_load = 1'b0;
    endtask

    task automatic runLength(input logic level, input int limit, output int n);
        n = 0;
        while (mmcm_rst === level && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic waitSettled(input int target, input string tag);
        int n;
        n = 0;
        while ((phase_current !== PW'(target) || ps_busy !== 1'b0) && n < 600) begin
            n++;
            tick();
        end
        checkOutput(tag, 32'(n < 600), 32'd1);
    endtask

    initial begin
        int n;
        int model_phase;
        int t;
        int inc_base;
        int dec_base;
        logic [NCH-1:0] exp_lanes;

        reset = 1'b1;
        mmcm_locked = 1'b0;
        phase_target = '0;
        phase_load = 1'b0;
        repeat (3) tick();

        checkOutput("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        checkOutput("rst_ps_en", 32'(ps_en), 32'd0);
        checkOutput("rst_ps_incdec", 32'(ps_incdec), 32'd0);
        checkOutput("rst_phase", 32'(phase_current), 32'd0);
        checkOutput("rst_ps_busy", 32'(ps_busy), 32'd0);
        checkOutput("rst_serdes", 32'(serdes_rst), 32'(4'b1111));
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_llc", 32'(lock_loss_cnt), 32'd0);

        // No lock: MMCM reset pulse, full timeout, then a retry pulse.
        reset = 1'b0;
        runLength(1'b1, 50, n);
        checkOutput("mmcm_rst_len", 32'(n), 32'(RSTC));
        runLength(1'b0, 500, n);
        checkOutput("lock_timeout_len", 32'(n), 32'(LTO));
        runLength(1'b1, 50, n);
        checkOutput("retry_rst_len", 32'(n), 32'(RSTC));

        // Lock arrives in WAIT_LOCK: locked_s 2 cycles later, release begins SETC cycles after that.
        mmcm_locked = 1'b1;
        for (int k = 0; k <= 2 + SETC + NCH; k++) begin
            for (int i = 0; i < NCH; i++) exp_lanes[i] = !(k >= 2 + SETC + i);
            checkOutput($sformatf("release_serdes_k%0d", k), 32'(serdes_rst), 32'(exp_lanes));
            checkOutput($sformatf("release_ready_k%0d", k), 32'(ready), 32'(k >= 2 + SETC + NCH));
            if (k < 2 + SETC + NCH) tick();
        end

        // Directed +3 target.
        model_phase = 0;
        inc_base = inc_count;
        dec_base = dec_count;
        applyStimulus(3);
        waitSettled(3, "settle_p3");
        checkOutput("phase_p3", 32'(phase_current), 32'sd3);
        checkOutput("incs_p3", 32'(inc_count - inc_base), 32'd3);
        checkOutput("decs_p3", 32'(dec_count - dec_base), 32'd0);
        checkOutput("busy_p3", 32'(ps_busy), 32'd0);
        model_phase = 3;

        // Random targets with random PSDONE latency.
        for (int r = 0; r < 6; r++) begin
            t = int'($urandom_range(0, 60)) - 30;
            resp_delay = int'($urandom_range(1, 4));
            inc_base = inc_count;
            dec_base = dec_count;
            applyStimulus(t);
            waitSettled(t, $sformatf("settle_rand%0d", r));
            checkOutput($sformatf("phase_rand%0d", r), 32'(phase_current), 32'(t));
            checkOutput($sformatf("incs_rand%0d", r), 32'(inc_count - inc_base),
                        32'((t > model_phase) ? t - model_phase : 0));
            checkOutput($sformatf("decs_rand%0d", r), 32'(dec_count - dec_base),
                        32'((t < model_phase) ? model_phase - t : 0));
            checkOutput($sformatf("ready_rand%0d", r), 32'(ready), 32'd1);
            model_phase = t;
        end

        // Retarget +5 -> -2 while the second increment is outstanding.
        resp_delay = 2;
        applyStimulus(0);
        waitSettled(0, "settle_zero");
        inc_base = inc_count;
        dec_base = dec_count;
        applyStimulus(5);
        n = 0;
        while (inc_count - inc_base < 2 && n < 100) begin
            n++;
            tick();
        end
        checkOutput("second_step_seen", 32'(n < 100), 32'd1);
        applyStimulus(-2);
        waitSettled(-2, "settle_retarget");
        checkOutput("phase_retarget", 32'(phase_current), 32'(-2));
        checkOutput("incs_retarget", 32'(inc_count - inc_base), 32'd2);
        checkOutput("decs_retarget", 32'(dec_count - dec_base), 32'd4);

        // Lock loss in RUN with target 3.
        applyStimulus(3);
        waitSettled(3, "settle_pre_loss");
        inc_base = inc_count;
        mmcm_locked = 1'b0;
        tick();
        checkOutput("ready_before_sync", 32'(ready), 32'd1);
        tick();
        checkOutput("loss_serdes", 32'(serdes_rst), 32'(4'b1111));
        checkOutput("loss_ready", 32'(ready), 32'd0);
        tick();
        checkOutput("loss_llc", 32'(lock_loss_cnt), 32'd1);
`ifdef SYZYGY_ADC_DCO_AUTO_RELOCK_EN
        checkOutput("relock_mmcm_rst", 32'(mmcm_rst), 32'd1);
        checkOutput("relock_fault", 32'(fault), 32'd0);
        tick();
        tick();
        checkOutput("relock_phase_cleared", 32'(phase_current), 32'd0);
        mmcm_locked = 1'b1;
        n = 0;
        while ((ready !== 1'b1 || phase_current !== PW'(3) || ps_busy !== 1'b0) && n < 600) begin
            n++;
            tick();
        end
        checkOutput("relock_settled", 32'(n < 600), 32'd1);
        checkOutput("relock_phase", 32'(phase_current), 32'sd3);
        checkOutput("relock_incs", 32'(inc_count - inc_base), 32'd3);
        checkOutput("relock_ready", 32'(ready), 32'd1);
        checkOutput("relock_llc", 32'(lock_loss_cnt), 32'd1);
`else
        checkOutput("loss_fault", 32'(fault), 32'd1);
        checkOutput("loss_mmcm_rst", 32'(mmcm_rst), 32'd0);
        repeat (10) tick();
        checkOutput("fault_hold", 32'(fault), 32'd1);
        checkOutput("fault_mmcm_rst", 32'(mmcm_rst), 32'd0);
        checkOutput("fault_serdes", 32'(serdes_rst), 32'(4'b1111));
        mmcm_locked = 1'b1;
        repeat (30) tick();
        checkOutput("fault_no_relock_ready", 32'(ready), 32'd0);
        checkOutput("fault_no_relock_fault", 32'(fault), 32'd1);
`endif

        // Mid-operation reset clears everything immediately.
        reset = 1'b1;
        #1;
        checkOutput("midrst_fault", 32'(fault), 32'd0);
        checkOutput("midrst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        checkOutput("midrst_serdes", 32'(serdes_rst), 32'(4'b1111));
        checkOutput("midrst_phase", 32'(phase_current), 32'd0);
        checkOutput("midrst_busy", 32'(ps_busy), 32'd0);
        checkOutput("midrst_llc", 32'(lock_loss_cnt), 32'd0);
        tick();
        reset = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checkOutput("bringup_ready", 32'(ready), 32'd1);

        // PSDONE never comes back.
        resp_on = 1'b0;
        applyStimulus(1);
        n = 0;
        while (ps_en !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checkOutput("timeout_ps_en_seen", 32'(ps_en), 32'd1);
        repeat (PSTO - 1) tick();
        checkOutput("timeout_fault_early", 32'(fault), 32'd0);
        tick();
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_ready", 32'(ready), 32'd0);
        checkOutput("timeout_serdes", 32'(serdes_rst), 32'(4'b1111));
        repeat (5) tick();
        checkOutput("timeout_fault_sticky", 32'(fault), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("final_rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
